// File: rtl/ads8689_spi_if.sv
// Handshake between the ADS8689 sequencer and the ADSPI SPI engine.
// One trigger outstanding at a time; the engine answers each with one spi_done.
interface ads8689_spi_if;
    logic        spi_wr_trig;
    logic        spi_rd_trig;
    logic [5:0]  spi_rw_len;
    logic [31:0] spi_wr_value;
    logic [31:0] spi_rd_value;
    logic        spi_done;

    modport master (
        output spi_wr_trig,
        output spi_rd_trig,
        output spi_rw_len,
        output spi_wr_value,
        input  spi_rd_value,
        input  spi_done
    );

    modport slave (
        input  spi_wr_trig,
        input  spi_rd_trig,
        input  spi_rw_len,
        input  spi_wr_value,
        output spi_rd_value,
        output spi_done
    );
endinterface

// File: rtl/ads8689_seq.sv
// ADS8689 channel sequencer: two config writes, then periodic conversions.
// Captures each 16-bit result and flags a missing spi_done as ad_err.
module ads8689_seq #(
    parameter logic [15:0] SMP_PERIOD = 16'd2000,
    parameter logic [15:0] TMO_CYC    = 16'd4000,
    parameter logic [7:0]  GAP_CYC    = 8'd20
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,
    input  logic          en,
    input  logic [3:0]    cfg_range,
    ads8689_spi_if.master spi,
    output logic          init_done,
    output logic [15:0]   ad_data,
    output logic          ad_valid,
    output logic          ad_err
);

    typedef enum logic [3:0] {
        IDLE, WR0, WAIT0, GAP0, WR1, WAIT1, CONV, CWAIT, PERIOD
    } state_t;

    localparam logic [31:0] W1 = {8'hD0, 8'h10, 16'h0000};

    state_t      state;
    state_t      state_nx;
    logic [15:0] per_cnt;
    logic [15:0] tmo_cnt;
    logic [7:0]  gap_cnt;
    logic [3:0]  range_q;
    logic        in_wait;
    logic        tmo_hit;

    assign in_wait = (state == WAIT0) || (state == WAIT1) || (state == CWAIT);
    // A done landing on the expiry cycle wins over the timeout
    assign tmo_hit = in_wait && (tmo_cnt == TMO_CYC - 16'd1) && !spi.spi_done;
    assign ad_err  = tmo_hit;
    assign spi.spi_rw_len = 6'd32;

    always_comb begin
        state_nx        = state;
        spi.spi_wr_trig = 1'b0;
        spi.spi_rd_trig = 1'b0;
        unique case (state)
            IDLE: if (en) state_nx = WR0;
            WR0: begin
                spi.spi_wr_trig = 1'b1;
                state_nx = WAIT0;
            end
            WAIT0: begin
                if (spi.spi_done)  state_nx = GAP0;
                else if (tmo_hit)  state_nx = IDLE;
            end
            GAP0: begin
                if (!en)                state_nx = IDLE;
                else if (gap_cnt == '0) state_nx = WR1;
            end
            WR1: begin
                spi.spi_wr_trig = 1'b1;
                state_nx = WAIT1;
            end
            WAIT1: begin
                if (spi.spi_done)  state_nx = CONV;
                else if (tmo_hit)  state_nx = IDLE;
            end
            CONV: begin
                spi.spi_rd_trig = 1'b1;
                state_nx = CWAIT;
            end
            CWAIT: begin
                if (spi.spi_done)  state_nx = PERIOD;
                else if (tmo_hit)  state_nx = IDLE;
            end
            PERIOD: begin
                if (!en)                       state_nx = IDLE;
                else if (cfg_range != range_q) state_nx = WR0;
                else if (per_cnt <= 16'd1)     state_nx = CONV;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state            <= IDLE;
            per_cnt          <= '0;
            tmo_cnt          <= '0;
            gap_cnt          <= '0;
            range_q          <= '0;
            spi.spi_wr_value <= '0;
            init_done        <= 1'b0;
            ad_data          <= '0;
            ad_valid         <= 1'b0;
        end else begin
            state    <= state_nx;
            ad_valid <= (state == CWAIT) && spi.spi_done;
            if ((state == CWAIT) && spi.spi_done)
                ad_data <= spi.spi_rd_value[31:16];
            tmo_cnt <= (in_wait && state_nx == state) ? tmo_cnt + 16'd1 : '0;
            // Reload at the trigger so trigger-to-trigger is exactly SMP_PERIOD
            if (spi.spi_rd_trig || ((state == WAIT1) && spi.spi_done))
                per_cnt <= SMP_PERIOD - 16'd1;
            else if (per_cnt != '0)
                per_cnt <= per_cnt - 16'd1;
            if ((state == WAIT0) && spi.spi_done)
                gap_cnt <= GAP_CYC - 8'd1;
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 8'd1;
            if (state_nx == WR0) begin
                range_q          <= cfg_range;
                spi.spi_wr_value <= {8'hD0, 8'h14, 12'h000, cfg_range};
            end
            if (state_nx == WR1)
                spi.spi_wr_value <= W1;
            if ((state == WAIT1) && spi.spi_done)
                init_done <= 1'b1;
            if ((state_nx == IDLE) || (state_nx == WR0))
                init_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ads8689_seq.sv
// Bench for ads8689_seq: engine model answering triggers after 700 clk,
// scoreboards for config words and conversion results.
module tb_ads8689_seq;
    localparam int DONE_DLY = 700;
    localparam int SMP      = 2000;
    localparam int TMO      = 4000;

    logic        clk_sys   = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        en        = 1'b0;
    logic [3:0]  cfg_range = 4'h0;
    logic        init_done;
    logic [15:0] ad_data;
    logic        ad_valid;
    logic        ad_err;

    ads8689_spi_if spi();

    ads8689_seq dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .en        (en),
        .cfg_range (cfg_range),
        .spi       (spi),
        .init_done (init_done),
        .ad_data   (ad_data),
        .ad_valid  (ad_valid),
        .ad_err    (ad_err)
    );

    always #5 clk_sys = ~clk_sys;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int n_wr         = 0;
    int n_rd         = 0;
    int n_valid      = 0;
    int n_err        = 0;
    int exp_err      = 0;
    int eng_cnt      = 0;
    int trig_cyc     = 0;
    int last_rd_cyc  = -1;
    int done_cyc     = -10;
    int withhold_idx = 0;
    bit eng_rd       = 1'b0;
    bit quiet        = 1'b0;
    logic [31:0] eng_wr_val;
    logic [31:0] exp_w;
    logic [15:0] exp_d;
    logic [31:0] rd_word;
    logic [31:0] wr_q[$];
    logic [15:0] ad_q[$];
    logic [31:0] rd_pat[4] = '{32'hABCD_0000, 32'h0001_FFFF,
                               32'hFFFF_1234, 32'h8001_5A5A};

    // Engine model plus output monitors, one process for a fixed order
    initial begin
        spi.spi_done     = 1'b0;
        spi.spi_rd_value = '0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            spi.spi_done = 1'b0;
            if (!rst_sys_n) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0 && !(eng_rd && n_rd == withhold_idx)) begin
                        spi.spi_done = 1'b1;
                        done_cyc = cyc;
                        if (eng_rd) begin
                            rd_word = rd_pat[n_rd % 4];
                            spi.spi_rd_value = rd_word;
                            ad_q.push_back(rd_word[31:16]);
                        end else begin
                            tests_run++;
                            if (spi.spi_wr_value !== eng_wr_val) begin
                                tests_failed++;
                                $display("FAIL wr_stable: got %h want %h",
                                         spi.spi_wr_value, eng_wr_val);
                            end
                        end
                    end
                end
                if (spi.spi_wr_trig || spi.spi_rd_trig) begin
                    tests_run++;
                    if (eng_cnt != 0 || quiet ||
                        (spi.spi_wr_trig && spi.spi_rd_trig)) begin
                        tests_failed++;
                        $display("FAIL trig_legal: wr=%b rd=%b busy=%0d quiet=%b",
                                 spi.spi_wr_trig, spi.spi_rd_trig, eng_cnt, quiet);
                    end
                    eng_cnt    = DONE_DLY;
                    eng_rd     = spi.spi_rd_trig;
                    trig_cyc   = cyc;
                    eng_wr_val = spi.spi_wr_value;
                end
            end
            #1;
            if (rst_sys_n) begin
                if (spi.spi_wr_trig) begin
                    n_wr++;
                    last_rd_cyc = -1;
                    tests_run++;
                    if (wr_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL wr_word: got %h want none", spi.spi_wr_value);
                    end else begin
                        exp_w = wr_q.pop_front();
                        if (spi.spi_wr_value !== exp_w) begin
                            tests_failed++;
                            $display("FAIL wr_word: got %h want %h",
                                     spi.spi_wr_value, exp_w);
                        end
                    end
                end
                if (spi.spi_rd_trig) begin
                    n_rd++;
                    if (last_rd_cyc >= 0) begin
                        tests_run++;
                        if (cyc - last_rd_cyc != SMP) begin
                            tests_failed++;
                            $display("FAIL rd_spacing: got %0d want %0d",
                                     cyc - last_rd_cyc, SMP);
                        end
                    end
                    last_rd_cyc = cyc;
                end
                if (ad_valid) begin
                    n_valid++;
                    tests_run++;
                    if (cyc - done_cyc != 1) begin
                        tests_failed++;
                        $display("FAIL valid_lat: got %0d want 1", cyc - done_cyc);
                    end
                    tests_run++;
                    if (ad_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL ad_data: got %h want none", ad_data);
                    end else begin
                        exp_d = ad_q.pop_front();
                        if (ad_data !== exp_d) begin
                            tests_failed++;
                            $display("FAIL ad_data: got %h want %h", ad_data, exp_d);
                        end
                    end
                end
                if (ad_err) begin
                    n_err++;
                    last_rd_cyc = -1;
                    tests_run++;
                    if (exp_err == 0 || cyc - trig_cyc != TMO) begin
                        tests_failed++;
                        $display("FAIL ad_err: at %0d want %0d expected=%0d",
                                 cyc - trig_cyc, TMO, exp_err);
                    end
                    if (exp_err > 0) exp_err--;
                end
            end
        end
    end

    task automatic test_reset();
        rst_sys_n = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk_sys);
        tests_run++;
        if ({init_done, ad_valid, ad_err, spi.spi_wr_trig, spi.spi_rd_trig} !== 5'b0) begin
            tests_failed++;
            $display("FAIL rst_strobes: got %b want 00000",
                     {init_done, ad_valid, ad_err, spi.spi_wr_trig, spi.spi_rd_trig});
        end
        tests_run++;
        if (ad_data !== 16'h0 || spi.spi_wr_value !== 32'h0 || spi.spi_rw_len !== 6'd32) begin
            tests_failed++;
            $display("FAIL rst_values: got %h %h %0d want 0 0 32",
                     ad_data, spi.spi_wr_value, spi.spi_rw_len);
        end
        rst_sys_n = 1'b1;
    endtask

    task automatic test_init();
        cfg_range = 4'h1;
        wr_q.push_back(32'hD014_0001);
        wr_q.push_back(32'hD010_0000);
        en = 1'b1;
        for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk_sys);
        tests_run++;
        if (init_done !== 1'b1 || n_wr != 2 || wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL init: done=%b writes=%0d left=%0d want 1 2 0",
                     init_done, n_wr, wr_q.size());
        end
    endtask

    task automatic test_steady();
        for (int i = 0; i < 6000 && n_valid < 2; i++) @(negedge clk_sys);
        tests_run++;
        if (n_valid != 2 || init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL steady: valids=%0d init=%b want 2 1", n_valid, init_done);
        end
    endtask

    task automatic test_timeout();
        int v;
        withhold_idx = n_rd + 1;
        exp_err = 1;
        wr_q.push_back(32'hD014_0001);
        wr_q.push_back(32'hD010_0000);
        for (int i = 0; i < 7000 && n_err < 1; i++) @(negedge clk_sys);
        tests_run++;
        if (n_err != 1 || init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout: errs=%0d init=%b want 1 0", n_err, init_done);
        end
        for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk_sys);
        v = n_valid;
        for (int i = 0; i < 3000 && n_valid <= v; i++) @(negedge clk_sys);
        tests_run++;
        if (n_valid != v + 1 || init_done !== 1'b1 || wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reinit: valids=%0d init=%b left=%0d want %0d 1 0",
                     n_valid, init_done, wr_q.size(), v + 1);
        end
    endtask

    task automatic test_range_change();
        int r;
        int v;
        int w;
        r = n_rd;
        for (int i = 0; i < 3000 && n_rd <= r; i++) @(negedge clk_sys);
        cfg_range = 4'h3;
        wr_q.push_back(32'hD014_0003);
        wr_q.push_back(32'hD010_0000);
        v = n_valid;
        w = n_wr;
        for (int i = 0; i < 3000 && n_wr <= w; i++) @(negedge clk_sys);
        tests_run++;
        if (n_wr != w + 1 || n_valid != v + 1 || n_rd != r + 1) begin
            tests_failed++;
            $display("FAIL range_order: wr=%0d valid=%0d rd=%0d want %0d %0d %0d",
                     n_wr, n_valid, n_rd, w + 1, v + 1, r + 1);
        end
        for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk_sys);
        for (int i = 0; i < 3000 && n_valid < v + 2; i++) @(negedge clk_sys);
        tests_run++;
        if (n_valid != v + 2 || wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL range_resume: valids=%0d left=%0d want %0d 0",
                     n_valid, wr_q.size(), v + 2);
        end
    endtask

    task automatic test_stop();
        int r;
        int v;
        int w;
        r = n_rd;
        for (int i = 0; i < 3000 && n_rd <= r; i++) @(negedge clk_sys);
        en = 1'b0;
        quiet = 1'b1;
        v = n_valid;
        w = n_wr;
        for (int i = 0; i < 1500 && n_valid <= v; i++) @(negedge clk_sys);
        repeat (3000) @(negedge clk_sys);
        tests_run++;
        if (n_valid != v + 1 || n_rd != r + 1 || n_wr != w || init_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop: valid=%0d rd=%0d wr=%0d init=%b want %0d %0d %0d 0",
                     n_valid, n_rd, n_wr, init_done, v + 1, r + 1, w);
        end
    endtask

    task automatic test_reset_midframe();
        int w;
        quiet = 1'b0;
        wr_q.push_back(32'hD014_0003);
        wr_q.push_back(32'hD010_0000);
        w = n_wr;
        en = 1'b1;
        for (int i = 0; i < 100 && n_wr <= w; i++) @(negedge clk_sys);
        repeat (100) @(negedge clk_sys);
        tests_run++;
        if (spi.spi_wr_value !== 32'hD014_0003 || ad_data === 16'h0) begin
            tests_failed++;
            $display("FAIL pre_rst: got %h %h want d0140003 nonzero",
                     spi.spi_wr_value, ad_data);
        end
        rst_sys_n = 1'b0;
        #1;
        tests_run++;
        if (spi.spi_wr_value !== 32'h0 || ad_data !== 16'h0 || init_done !== 1'b0 ||
            ad_valid !== 1'b0 || ad_err !== 1'b0 || spi.spi_rw_len !== 6'd32) begin
            tests_failed++;
            $display("FAIL async_rst: got %h %h %b%b%b %0d want 0 0 000 32",
                     spi.spi_wr_value, ad_data, init_done, ad_valid, ad_err,
                     spi.spi_rw_len);
        end
        wr_q.delete();
        en = 1'b0;
        quiet = 1'b1;
        repeat (3) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        repeat (50) @(negedge clk_sys);
        tests_run++;
        if (init_done !== 1'b0 || ad_data !== 16'h0) begin
            tests_failed++;
            $display("FAIL post_rst: init=%b data=%h want 0 0", init_done, ad_data);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_steady();
        test_timeout();
        test_range_change();
        test_stop();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

endmodule
